banco_registro_param: RTL and testbench
=======================================

BANCO_REGISTRO_PARAM -- requirements
Module: banco_registro_param

Interface
REQ-001 SHALL have parameter W, default 6, meaning data width in bits.
REQ-002 SHALL have parameter N, default 6, meaning address width, giving 2**N registers.
REQ-003 SHALL have parameter NR, default 2, meaning number of read ports (range 1..4).
REQ-004 SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-low.
REQ-007 SHALL have port we, input, 1 bit, meaning write enable.
REQ-008 SHALL have port addr_rd, input, N bits, meaning write address.
REQ-009 SHALL have port data_in, input, W bits, meaning write data.
REQ-010 SHALL have port addr_rs, input, NR*N bits, meaning read addresses; port k uses slice [k*N +: N].
REQ-011 SHALL have port rs, output, NR*W bits, meaning read data; port k drives slice [k*W +: W].
REQ-012 SHALL have port res, input, 1 bit, meaning reserve request: marks a register as awaiting a write.
REQ-013 SHALL have port addr_res, input, N bits, meaning the address to reserve.
REQ-014 SHALL have port pend, output, NR bits, meaning bit k is 1 when read port k's address is reserved.
REQ-015 SHALL have port clr, input, 1 bit, meaning start a bulk clear of the whole file.
REQ-016 SHALL have port busy, output, 1 bit, meaning a bulk clear is in progress.

Function
REQ-017 SHALL make register 0 read as zero, never reserved, and ignore writes to it.
REQ-018 SHALL make reads combinational (zero latency) on every port independently.
REQ-019 SHALL, when BYPASS=1, forward data_in to read port k in the same cycle when we=1, busy=0, and addr_rd==addr_rs[k]!=0; when BYPASS=0, that port SHALL return the old value until the next cycle.
REQ-020 SHALL perform a write, when we=1, busy=0 and addr_rd!=0, at the next rising edge.
REQ-021 SHALL keep one pending bit per register: res=1 sets the bit at addr_res; an accepted write clears the bit at addr_rd; when both target the same address in the same cycle, the bit SHALL end set.
REQ-022 SHALL drive pend[k] from the pending bit at addr_rs[k]; when BYPASS=1 and a same-cycle accepted write matches, pend[k] SHALL be 0.
REQ-023 SHALL implement a state machine with states IDLE and CLEAR.
REQ-024 SHALL, in IDLE, on clr=1 enter CLEAR, load the clear counter with 1, and zero all pending bits at the same edge.
REQ-025 SHALL, in CLEAR, write zero to the register at the counter address each cycle and increment the counter, returning to IDLE after address 2**N-1 is written (2**N-1 cycles in CLEAR).
REQ-026 SHALL hold busy=1 exactly while in CLEAR.
REQ-027 SHALL, while busy=1, ignore we, res and clr; reads SHALL return current storage contents.
REQ-028 SHALL, on a same-cycle clr=1 and we=1 in IDLE, perform the write and then start the clear.

Reset
REQ-029 SHALL, when rst=0 at a rising edge, zero all registers and all pending bits, set the state to IDLE, set busy=0, and zero the counter.
REQ-030 SHALL abort a bulk clear when reset arrives mid-operation, with the REQ-029 result.
REQ-031 SHALL produce rs=0 and pend=0 after reset, whatever the read addresses.

Structure
REQ-032 SHALL place the state enum (IDLE, CLEAR) and the default parameter constants in package banco_pkg.
REQ-033 SHALL use one sub-module, puerto_lectura, for the zero/bypass/pending mux of one read port, instantiated NR times by generate.

Verification
REQ-034 SHALL verify write then read: write 6'h2A to address 5, then read port 0 at address 5 on the next cycle -> rs[0]=6'h2A, pend[0]=0.
REQ-035 SHALL verify the zero register: write 6'h3F to address 0 -> every port reading address 0 returns 0.
REQ-036 SHALL verify forwarding: in the same cycle, we=1, addr_rd=7, data_in=6'h11, addr_rs[1]=7 -> rs[1]=6'h11 with BYPASS=1, or the old value with BYPASS=0.
REQ-037 SHALL verify the scoreboard: reserve address 9, then read it -> pend=1; write 9 with a same-cycle reserve of 9 -> pend stays 1; write 9 alone -> pend=0.
REQ-038 SHALL verify bulk clear: fill addresses 1..63 with nonzero data, pulse clr -> busy=1 for 63 cycles, writes during busy are ignored, and all reads return 0 afterwards.
REQ-039 SHALL verify reset mid-clear: assert rst=0 at cycle 20 of a clear -> next cycle state is IDLE, busy=0, all registers 0.

Source files
------------

// File: rtl/banco_pkg.sv
// Shared definitions for the parameterised register file.
//   - default parameter constants for banco_registro_param / puerto_lectura
//   - estado_t : bulk-clear state machine encoding (IDLE, CLEAR)
package banco_pkg;

  localparam int unsigned W_DEF      = 6;  // data width
  localparam int unsigned N_DEF      = 6;  // address width (2**N registers)
  localparam int unsigned NR_DEF     = 2;  // number of read ports
  localparam int unsigned BYPASS_DEF = 1;  // write-to-read forwarding

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } estado_t;

endpackage

// File: rtl/puerto_lectura.sv
// One read port: zero-register masking, optional write forwarding and
// pending-bit selection. Purely combinational.
//   addr     : read address of this port
//   dato_mem : storage contents at addr
//   pend_mem : pending bit at addr
//   wr_acc   : a write is being accepted this cycle (already excludes addr 0 / busy)
//   addr_wr  : write address
//   dato_wr  : write data
//   dato_c   : read data
//   pend_c   : pending flag seen by this port
module puerto_lectura
  import banco_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned N      = N_DEF,
  parameter int unsigned BYPASS = BYPASS_DEF
) (
  input  logic [N-1:0] addr,
  input  logic [W-1:0] dato_mem,
  input  logic         pend_mem,
  input  logic         wr_acc,
  input  logic [N-1:0] addr_wr,
  input  logic [W-1:0] dato_wr,
  output logic [W-1:0] dato_c,
  output logic         pend_c
);

  // Register 0 wins over everything; a forwarded write also hides the reservation
  // it is about to retire.
  always_comb begin
    dato_c = dato_mem;
    pend_c = pend_mem;
    if (addr == '0) begin
      dato_c = '0;
      pend_c = 1'b0;
    end else if ((BYPASS != 0) && wr_acc && (addr_wr == addr)) begin
      dato_c = dato_wr;
      pend_c = 1'b0;
    end
  end

endmodule

// File: rtl/banco_registro_param.sv
// Parameterised register file with NR combinational read ports, one write
// port, a per-register pending (reservation) scoreboard and a bulk clear.
//   clk, rst (sync, active-low)
//   we, addr_rd, data_in : write port
//   addr_rs, rs          : NR read ports, slices of N / W bits
//   res, addr_res        : reserve a register as awaiting a write
//   pend                 : per read port, reserved flag
//   clr, busy            : start / in-progress indication of bulk clear
module banco_registro_param
  import banco_pkg::*;
#(
  parameter int unsigned W      = W_DEF,
  parameter int unsigned N      = N_DEF,
  parameter int unsigned NR     = NR_DEF,
  parameter int unsigned BYPASS = BYPASS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [N-1:0]    addr_rd,
  input  logic [W-1:0]    data_in,
  input  logic [NR*N-1:0] addr_rs,
  output logic [NR*W-1:0] rs,
  input  logic            res,
  input  logic [N-1:0]    addr_res,
  output logic [NR-1:0]   pend,
  input  logic            clr,
  output logic            busy
);

  localparam int unsigned DEPTH = 2 ** N;
  localparam logic [N-1:0] LAST = N'(DEPTH - 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  estado_t          estado_q, estado_d;
  logic [N-1:0]     cnt_q, cnt_d;
  logic             wr_acc;

  assign busy   = (estado_q == CLEAR);
  assign wr_acc = we && !busy && (addr_rd != '0);

  // State and clear-counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next state: the counter starts at 1 because register 0 is hardwired.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    case (estado_q)
      IDLE: begin
        if (clr) begin
          estado_d = CLEAR;
          cnt_d    = N'(1);
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + N'(1);
        if (cnt_q == LAST) estado_d = IDLE;
      end
    endcase
  end

  // Storage: clear sweep while busy, otherwise the normal write port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_acc) begin
      mem_q[addr_rd] <= data_in;
    end
  end

  // Scoreboard: reserve is written last so it wins over a same-address write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
    end else if (!busy) begin
      if (clr) begin
        pend_q <= '0;
      end else begin
        if (wr_acc) pend_q[addr_rd] <= 1'b0;
        if (res && (addr_res != '0)) pend_q[addr_res] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_port
    logic [N-1:0] a;
    assign a = addr_rs[k*N +: N];

    puerto_lectura #(
      .W      (W),
      .N      (N),
      .BYPASS (BYPASS)
    ) u_port (
      .addr     (a),
      .dato_mem (mem_q[a]),
      .pend_mem (pend_q[a]),
      .wr_acc   (wr_acc),
      .addr_wr  (addr_rd),
      .dato_wr  (data_in),
      .dato_c   (rs[k*W +: W]),
      .pend_c   (pend[k])
    );
  end

endmodule

// File: tb/tb_banco_registro_param.sv
// Self-checking bench for banco_registro_param: directed scenarios plus a
// randomized run, all compared against an array-based reference model.
module tb_banco_registro_param;

  localparam int unsigned W      = 6;
  localparam int unsigned N      = 6;
  localparam int unsigned NR     = 2;
  localparam int unsigned BYPASS = 1;
  localparam int unsigned DEPTH  = 2 ** N;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [N-1:0]    addr_rd;
  logic [W-1:0]    data_in;
  logic [NR*N-1:0] addr_rs;
  logic [NR*W-1:0] rs;
  logic            res;
  logic [N-1:0]    addr_res;
  logic [NR-1:0]   pend;
  logic            clr;
  logic            busy;

  banco_registro_param #(.W(W), .N(N), .NR(NR), .BYPASS(BYPASS)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr_rd  (addr_rd),
    .data_in  (data_in),
    .addr_rs  (addr_rs),
    .rs       (rs),
    .res      (res),
    .addr_res (addr_res),
    .pend     (pend),
    .clr      (clr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  int m_mem  [DEPTH];
  bit m_pend [DEPTH];
  bit m_busy;
  int m_pos;   // next address the clear sweep will zero

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = 0;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_pos  = 0;
  endtask

  // Applies the inputs present at the rising edge that just happened.
  task automatic model_update();
    if (!rst) begin
      model_reset();
    end else if (m_busy) begin
      m_mem[m_pos] = 0;
      if (m_pos == DEPTH - 1) m_busy = 1'b0;
      m_pos++;
    end else begin
      if (we && addr_rd != 0) begin
        m_mem[addr_rd]  = int'(data_in);
        m_pend[addr_rd] = 1'b0;
      end
      if (res && addr_res != 0) m_pend[addr_res] = 1'b1;
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
        m_busy = 1'b1;
        m_pos  = 1;
      end
    end
  endtask

  task automatic check_outputs();
    int a;
    int ed;
    bit ep;
    for (int k = 0; k < NR; k++) begin
      a  = int'(addr_rs[k*N +: N]);
      ed = m_mem[a];
      ep = m_pend[a];
      if (a == 0) begin
        ed = 0;
        ep = 1'b0;
      end else if (BYPASS != 0 && we && !m_busy && int'(addr_rd) == a) begin
        ed = int'(data_in);
        ep = 1'b0;
      end
      check($sformatf("rs%0d@%0d", k, a), 32'(rs[k*W +: W]), 32'(ed));
      check($sformatf("pend%0d@%0d", k, a), 32'(pend[k]), 32'(ep));
    end
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  // Inputs are already set; check mid-cycle, clock, update model, re-drive.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b1; we = 1'b0; res = 1'b0; clr = 1'b0;
    addr_rd = '0; data_in = '0; addr_res = '0; addr_rs = '0;
  endtask

  task automatic set_rs(input int k, input logic [N-1:0] a);
    addr_rs[k*N +: N] = a;
  endtask

  task automatic write_reg(input logic [N-1:0] a, input logic [W-1:0] d);
    idle_inputs();
    we = 1'b1; addr_rd = a; data_in = d;
    step();
  endtask

  // Reads every address through port 0 and requires zero data.
  task automatic sweep_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      idle_inputs();
      set_rs(0, N'(a));
      #1;
      check($sformatf("%s@%0d", tag, a), 32'(rs[W-1:0]), 32'd0);
      step();
    end
  endtask

  initial begin
    model_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    model_update();
    #1;

    // Reset output state with arbitrary read addresses
    addr_rs = NR*N'($urandom);
    #1;
    check("rst_rs", 32'(rs), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    step();

    // Write then read
    write_reg(N'(5), W'(6'h2A));
    idle_inputs();
    set_rs(0, N'(5));
    #1;
    check("wr_rd_data", 32'(rs[W-1:0]), 32'h2A);
    check("wr_rd_pend", 32'(pend[0]), 32'd0);
    step();

    // Zero register
    write_reg(N'(0), W'(6'h3F));
    idle_inputs();
    #1;
    for (int k = 0; k < NR; k++)
      check($sformatf("zero_reg%0d", k), 32'(rs[k*W +: W]), 32'd0);
    step();

    // Forwarding
    write_reg(N'(7), W'(6'h05));
    idle_inputs();
    we = 1'b1; addr_rd = N'(7); data_in = W'(6'h11); set_rs(1, N'(7));
    #1;
    check("bypass", 32'(rs[2*W-1:W]), (BYPASS != 0) ? 32'h11 : 32'h05);
    step();

    // Scoreboard
    idle_inputs(); res = 1'b1; addr_res = N'(9); step();
    idle_inputs(); set_rs(0, N'(9)); #1;
    check("res_set", 32'(pend[0]), 32'd1);
    step();
    idle_inputs(); we = 1'b1; addr_rd = N'(9); data_in = W'(6'h01);
    res = 1'b1; addr_res = N'(9); step();
    idle_inputs(); set_rs(0, N'(9)); #1;
    check("res_wr_same", 32'(pend[0]), 32'd1);
    step();
    write_reg(N'(9), W'(6'h02));
    idle_inputs(); set_rs(0, N'(9)); #1;
    check("res_cleared", 32'(pend[0]), 32'd0);
    step();

    // Bulk clear with writes/reserves/clr attempted while busy
    for (int a = 1; a < DEPTH; a++) write_reg(N'(a), W'((a % 63) + 1));
    idle_inputs(); clr = 1'b1; step();
    for (int c = 0; c < DEPTH - 1; c++) begin
      idle_inputs();
      we = 1'b1; addr_rd = N'($urandom_range(1, DEPTH - 1)); data_in = W'($urandom_range(1, 63));
      res = 1'b1; addr_res = N'($urandom); clr = 1'($urandom);
      set_rs(0, addr_rd);
      #1;
      check($sformatf("clr_busy%0d", c), 32'(busy), 32'd1);
      step();
    end
    idle_inputs(); #1;
    check("clr_done", 32'(busy), 32'd0);
    sweep_zero("clr_zero");

    // Reset in the middle of a clear
    for (int a = 1; a < DEPTH; a++) write_reg(N'(a), W'($urandom_range(1, 63)));
    idle_inputs(); clr = 1'b1; step();
    for (int c = 0; c < 19; c++) begin
      idle_inputs(); step();
    end
    idle_inputs(); rst = 1'b0; step();
    idle_inputs(); #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    sweep_zero("rst_mid_zero");

    // Randomized run; small address window raises collision rates
    for (int c = 0; c < 3000; c++) begin
      int unsigned lim;
      lim = ($urandom_range(0, 1) != 0) ? 7 : DEPTH - 1;
      rst      = ($urandom_range(0, 299) != 0);
      we       = 1'($urandom);
      res      = ($urandom_range(0, 2) == 0);
      clr      = ($urandom_range(0, 99) == 0);
      addr_rd  = N'($urandom_range(0, lim));
      addr_res = N'($urandom_range(0, lim));
      data_in  = W'($urandom);
      for (int k = 0; k < NR; k++) set_rs(k, N'($urandom_range(0, lim)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
